sb_symplectic_update: RTL and testbench
=======================================

// Module: sb_symplectic_update
// PURPOSE
// Symplectic-Euler update stage of the simulated-bifurcation core; sits directly upstream of the wall-collision stage.
// Per pass: applies pump-ramped detuning plus coupling field h to N oscillators, serially one element at a time.
// Produces updated x/y vectors for the wall-collision stage; owns the pump amplitude ramp a_t.
// PARAMETERS
// N           8   oscillators per vector
// DATA_WIDTH  32  signed fixed-point word width
// FRAC_WIDTH  16  fractional bits (1.0 = 2^FRAC_WIDTH)
// PORTS
// clk         in   1              clock, rising edge
// rst         in   1              synchronous reset, active-high
// valid_in    in   1              input vectors/config valid
// ready_out   out  1              stage can accept (high only in IDLE)
// x_in,y_in   in   N*DATA_WIDTH   current position/momentum (packed [N-1:0][DATA_WIDTH-1:0])
// h_in        in   N*DATA_WIDTH   coupling field sum_j J_ij*x_j
// dt,a0,c0    in   DATA_WIDTH     step, final pump, coupling gain; sampled on accept
// a_step      in   DATA_WIDTH     pump increment per pass, >= 0, sampled on accept
// pump_clear  in   1              force a_t to 0
// x_out,y_out out  N*DATA_WIDTH   updated vectors, held until next result
// a_t_out     out  DATA_WIDTH     current pump amplitude
// valid_out   out  1              one-cycle pulse: x_out/y_out new
// BEHAVIOUR
// - Reset: state IDLE, idx=0, x_out=y_out=0, a_t_out=0, valid_out=0, ready_out=1 after reset edge. rst mid-pass aborts; no valid_out.
// - Accept on edge with valid_in&&ready_out: latch x_in,y_in,h_in,dt,a0,c0,a_step; a_eff=a0-a_t; dt_a0=(dt*a0)>>>F; -> STEP_Y, idx=0.
// - FSM IDLE->STEP_Y->STEP_X->(idx<N-1: idx++, STEP_Y | idx==N-1: DONE)->IDLE. valid_in outside IDLE ignored.
// - STEP_Y(i): f=sat((c0*h[i])>>>F - (a_eff*x[i])>>>F); y[i]=sat(y[i]+(dt*f)>>>F).
// - STEP_X(i): x[i]=sat(x[i]+(dt_a0*y[i])>>>F), using the y[i] just written.
// - Products full 2*DATA_WIDTH signed; >>>F arithmetic (floor); sat clamps to [0x80..0, 0x7F..F] per DATA_WIDTH.
// - DONE: x_out/y_out<=working regs, valid_out=1 for this cycle only; a_t<=min(a_t+a_step, a0 latched).
// - Latency: valid_out high 2N+1 cycles after accept edge (17 for N=8); next accept earliest the cycle after DONE.
// - pump_clear: a_t<=0 next edge in any state; in-flight pass keeps its latched a_eff; clear at DONE wins over increment.
// - No bounds enforcement here: |x|>1 passed through to the downstream wall-collision stage.
// TESTING
// 1 Reset: assert rst 2 cycles -> all outputs 0, ready_out=1, valid_out=0.
// 2 Single pass N=8: dt=0x8000,a0=0x10000,c0=0,a_t=0,x=0x4000,y=0 -> y_out=0xFFFFE000, x_out=0x3000 all i, valid_out at accept+17.
// 3 Ramp: a_step=0x4000,a0=0x10000, 5 passes -> a_t_out 0x4000,0x8000,0xC000,0x10000,0x10000 (saturated).
// 4 Saturation: y=0x7FFF0000,c0=0x10000,h=0x7FFF0000,dt=0x10000 -> y_out=0x7FFFFFFF, no wrap.
// 5 Busy: valid_in high through pass -> only first accepted, ready_out=0 for cycles 1..17, second accepted after DONE.
// 6 Abort/clear: rst at accept+5 -> no valid_out, a_t_out=0; pump_clear in DONE cycle -> a_t_out=0.

Source files
------------

// File: rtl/sb_symplectic_update.sv
// Symplectic-Euler update stage: applies the pump-ramped detuning and the
// coupling field to N oscillators one element at a time, then hands the
// updated x/y vectors to the wall-collision stage. Owns the pump ramp a_t.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for valid_in; only state with ready_out high
// S_STEP_Y | momentum update of element idx
// S_STEP_X | position update of element idx using the fresh y[idx]
// S_DONE   | publish x_out/y_out, pulse valid_out, advance the pump ramp
module sb_symplectic_update #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  output logic                             ready_out,
  input  logic [N-1:0][DATA_WIDTH-1:0]     x_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     y_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     h_in,
  input  logic [DATA_WIDTH-1:0]            dt,
  input  logic [DATA_WIDTH-1:0]            a0,
  input  logic [DATA_WIDTH-1:0]            c0,
  input  logic [DATA_WIDTH-1:0]            a_step,
  input  logic                             pump_clear,
  output logic [N-1:0][DATA_WIDTH-1:0]     x_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     y_out,
  output logic [DATA_WIDTH-1:0]            a_t_out,
  output logic                             valid_out
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEP_Y = 2'd1;
  localparam logic [1:0] S_STEP_X = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                 state;
  logic [IW-1:0]              idx;
  logic [DW-1:0]              a_t;
  logic [N-1:0][DW-1:0]       x_w, y_w, h_w;
  logic [DW-1:0]              dt_r, c0_r, a0_r, a_step_r, a_eff_r, dt_a0_r;

  function automatic logic signed [PW-1:0] sx(input logic [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] ext2(input logic signed [PW-1:0] v);
    return {{2{v[PW-1]}}, v};
  endfunction

  // Clamp a wide two's-complement value into DATA_WIDTH bits.
  function automatic logic [DW-1:0] sat(input logic [SW-1:0] v);
    if ((&v[SW-1:DW-1]) || (~|v[SW-1:DW-1]))
      return v[DW-1:0];
    else if (v[SW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic [DW-1:0]          x_cur, y_cur, h_cur;
  logic signed [PW-1:0]   p_ch, p_ax, p_df, p_xy, p_acc;
  logic [DW-1:0]          f_val, y_new, x_new, dt_a0_new;
  logic signed [DW:0]     a_sum, a0_ext;
  logic [DW-1:0]          a_next;

  assign x_cur = x_w[idx];
  assign y_cur = y_w[idx];
  assign h_cur = h_w[idx];

  // Element datapath: the shared multipliers serve whichever half-step is active.
  always_comb begin
    p_ch      = sx(c0_r) * sx(h_cur);
    p_ax      = sx(a_eff_r) * sx(x_cur);
    f_val     = sat(ext2(p_ch >>> FRAC_WIDTH) - ext2(p_ax >>> FRAC_WIDTH));
    p_df      = sx(dt_r) * sx(f_val);
    y_new     = sat(ext2(sx(y_cur)) + ext2(p_df >>> FRAC_WIDTH));
    p_xy      = sx(dt_a0_r) * sx(y_cur);
    x_new     = sat(ext2(sx(x_cur)) + ext2(p_xy >>> FRAC_WIDTH));
    p_acc     = sx(dt) * sx(a0);
    dt_a0_new = DW'(p_acc >>> FRAC_WIDTH);
    a_sum     = $signed({a_t[DW-1], a_t}) + $signed({a_step_r[DW-1], a_step_r});
    a0_ext    = $signed({a0_r[DW-1], a0_r});
    a_next    = (a_sum > a0_ext) ? a0_r : a_sum[DW-1:0];
  end

  // Sequencing, published outputs and the pump ramp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      a_t       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            state <= S_STEP_Y;
            idx   <= '0;
          end
        end
        S_STEP_Y: state <= S_STEP_X;
        S_STEP_X: begin
          if (idx == IW'(N - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_STEP_Y;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          x_out     <= x_w;
          y_out     <= y_w;
          valid_out <= 1'b1;
          a_t       <= a_next;
        end
        default: state <= S_IDLE;
      endcase
      // A clear always overrides the ramp increment, even in S_DONE.
      if (pump_clear)
        a_t <= '0;
    end
  end

  // Working registers: loaded on accept, rewritten one element per half-step.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && valid_in) begin
      x_w      <= x_in;
      y_w      <= y_in;
      h_w      <= h_in;
      dt_r     <= dt;
      c0_r     <= c0;
      a0_r     <= a0;
      a_step_r <= a_step;
      a_eff_r  <= a0 - a_t;
      dt_a0_r  <= dt_a0_new;
    end else if (state == S_STEP_Y) begin
      y_w[idx] <= y_new;
    end else if (state == S_STEP_X) begin
      x_w[idx] <= x_new;
    end
  end

  assign ready_out = (state == S_IDLE);
  assign a_t_out   = a_t;

endmodule

// File: tb/tb_sb_symplectic_update.sv
// Bench for sb_symplectic_update: random and directed passes, expected
// results from an element-wise arithmetic model pushed into a scoreboard
// and checked by an independent monitor on valid_out.
module tb_sb_symplectic_update;
  localparam int N  = 8;
  localparam int VW = N * 32;
  localparam int LAT = 2 * N + 1;
  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic ready_out;
  logic [N-1:0][31:0] x_in = '0, y_in = '0, h_in = '0;
  logic [31:0] dt = '0, a0 = '0, c0 = '0, a_step = '0;
  logic pump_clear = 1'b0;
  logic [N-1:0][31:0] x_out, y_out;
  logic [31:0] a_t_out;
  logic valid_out;

  sb_symplectic_update #(.N(N), .DATA_WIDTH(32), .FRAC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .x_in(x_in), .y_in(y_in), .h_in(h_in), .dt(dt), .a0(a0), .c0(c0),
    .a_step(a_step), .pump_clear(pump_clear), .x_out(x_out), .y_out(y_out),
    .a_t_out(a_t_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][31:0] x;
    logic [N-1:0][31:0] y;
    logic [31:0]        at;
    int                 acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_at = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > IMAX) return int'(IMAX);
    if (v < IMIN) return int'(IMIN);
    return int'(v);
  endfunction

  // Reference: one Euler pass computed element by element with plain integers.
  task automatic model_pass(input logic [N-1:0][31:0] xv, yv, hv,
                            input int dtv, a0v, c0v, stv, clr_k, acc,
                            output exp_t r);
    int aeff, dta0, xi, yi, hi, base, nat;
    longint f, sum;
    aeff = a0v - m_at;
    dta0 = int'((longint'(dtv) * longint'(a0v)) >>> 16);
    for (int i = 0; i < N; i++) begin
      xi = xv[i]; yi = yv[i]; hi = hv[i];
      f  = longint'(sat(((longint'(c0v) * longint'(hi)) >>> 16) -
                        ((longint'(aeff) * longint'(xi)) >>> 16)));
      yi = sat(longint'(yi) + ((longint'(dtv) * f) >>> 16));
      xi = sat(longint'(xi) + ((longint'(dta0) * longint'(yi)) >>> 16));
      r.x[i] = xi;
      r.y[i] = yi;
    end
    base = (clr_k > 0 && clr_k < LAT) ? 0 : m_at;
    sum  = longint'(base) + longint'(stv);
    nat  = (sum > longint'(a0v)) ? a0v : int'(sum);
    if (clr_k == LAT) nat = 0;
    m_at  = nat;
    r.at  = nat;
    r.acc = acc;
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding pass.
  always @(negedge clk) begin
    if (!rst && valid_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid_out", VW'(1), VW'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
        chk("a_t_out", VW'(a_t_out), VW'(e.at));
        chk("latency", VW'(cyc - e.acc), VW'(LAT));
      end
    end
  end

  task automatic send(input logic [N-1:0][31:0] xv, yv, hv,
                      input int dtv, a0v, c0v, stv, clr_k, rst_k);
    exp_t e;
    int w, acc;
    @(negedge clk);
    x_in = xv; y_in = yv; h_in = hv;
    dt = dtv; a0 = a0v; c0 = c0v; a_step = stv;
    valid_in = 1'b1;
    w = 0;
    while (ready_out !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ready_out !== 1'b1) begin
      chk("accept_timeout", VW'(0), VW'(1));
      valid_in = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (rst_k == 0) begin
      model_pass(xv, yv, hv, dtv, a0v, c0v, stv, clr_k, acc, e);
      q.push_back(e);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (rst_k > 0) begin
      while (cyc < acc + rst_k - 1) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_at = 0;
    end else if (clr_k > 0) begin
      while (cyc < acc + clr_k - 1) @(negedge clk);
      pump_clear = 1'b1;
      @(posedge clk); #1;
      pump_clear = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain_timeout", VW'(q.size()), VW'(0));
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_word(input bit wide);
    if (wide) return $urandom();
    return $urandom_range(0, 32'h7FFFF) - 32'h40000;
  endfunction

  initial begin
    logic [N-1:0][31:0] xv, yv, hv, ev;
    logic [31:0] ramp [5];
    exp_t e1, e2;
    int low, acc, k;
    bit wide;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x_out", x_out, '0);
    chk("rst_y_out", y_out, '0);
    chk("rst_a_t", VW'(a_t_out), VW'(0));
    chk("rst_valid_out", VW'(valid_out), VW'(0));
    chk("rst_ready_out", VW'(ready_out), VW'(1));
    rst = 1'b0;

    // Single pass with known closed-form result.
    xv = {N{32'h0000_4000}}; yv = '0; hv = '0;
    send(xv, yv, hv, 32'h8000, 32'h10000, 0, 0, 0, 0);
    wait_idle();
    ev = {N{32'h0000_3000}};
    chk("single_x", x_out, ev);
    ev = {N{32'hFFFF_E000}};
    chk("single_y", y_out, ev);

    // Pump ramp saturating at a0.
    ramp[0] = 32'h4000; ramp[1] = 32'h8000; ramp[2] = 32'hC000;
    ramp[3] = 32'h10000; ramp[4] = 32'h10000;
    for (int p = 0; p < 5; p++) begin
      send(xv, yv, hv, 32'h1000, 32'h10000, 32'h800, 32'h4000, 0, 0);
      wait_idle();
      chk("ramp_a_t", VW'(a_t_out), VW'(ramp[p]));
    end

    // Saturation of the momentum update.
    xv = '0; yv = {N{32'h7FFF_0000}}; hv = {N{32'h7FFF_0000}};
    send(xv, yv, hv, 32'h10000, 0, 32'h10000, 0, 0, 0);
    wait_idle();
    ev = {N{32'h7FFF_FFFF}};
    chk("sat_y", y_out, ev);

    // Busy: valid_in held high across a whole pass.
    for (int i = 0; i < N; i++) begin
      xv[i] = rnd_word(0); yv[i] = rnd_word(0); hv[i] = rnd_word(0);
    end
    @(negedge clk);
    x_in = xv; y_in = yv; h_in = hv;
    dt = 32'h2000; a0 = 32'h18000; c0 = 32'h4000; a_step = 32'h3000;
    valid_in = 1'b1;
    acc = cyc + 1;
    model_pass(xv, yv, hv, 32'h2000, 32'h18000, 32'h4000, 32'h3000, 0, acc, e1);
    q.push_back(e1);
    @(posedge clk);
    low = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (ready_out === 1'b0) low++;
    end
    @(negedge clk);
    chk("busy_ready_low_cycles", VW'(low), VW'(LAT));
    chk("busy_ready_after_done", VW'(ready_out), VW'(1));
    acc = cyc + 1;
    model_pass(xv, yv, hv, 32'h2000, 32'h18000, 32'h4000, 32'h3000, 0, acc, e2);
    q.push_back(e2);
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_idle();

    // Abort by reset five edges into a pass.
    send(xv, yv, hv, 32'h2000, 32'h10000, 32'h4000, 32'h2000, 0, 5);
    repeat (25) @(negedge clk);
    chk("abort_a_t", VW'(a_t_out), VW'(0));
    chk("abort_x_out", x_out, '0);
    chk("abort_ready", VW'(ready_out), VW'(1));

    // pump_clear in the DONE cycle wins over the increment.
    send(xv, yv, hv, 32'h2000, 32'h10000, 32'h4000, 32'h4000, 0, 0);
    wait_idle();
    send(xv, yv, hv, 32'h2000, 32'h10000, 32'h4000, 32'h4000, LAT, 0);
    wait_idle();
    chk("clear_at_done_a_t", VW'(a_t_out), VW'(0));

    // Randomized passes, back to back where the driver allows.
    for (int p = 0; p < 40; p++) begin
      wide = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        xv[i] = rnd_word(wide); yv[i] = rnd_word(wide); hv[i] = rnd_word(wide);
      end
      k = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT) : 0;
      send(xv, yv, hv, $urandom_range(0, 32'h10000), $urandom_range(0, 32'h20000),
           $urandom_range(0, 32'h20000), $urandom_range(0, 32'h8000), k, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("scoreboard_empty", VW'(q.size()), VW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
